// File: rtl/uart_rx_fifo_v2.sv
// 16x-oversampled UART receiver (majority vote, parity/stop/bit-order options, error tags) into a show-ahead FIFO.
// Entry written one Clk after the last stop sample; no backpressure on Rx, full FIFO drops and flags overflow, RTS advises sender.
module uart_rx_fifo_v2 #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_THRESH = FIFO_DEPTH / 2 + 1,
    parameter int MSB_FIRST   = 1
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Baud_Tick,
    input  logic                          Rx,
    input  logic [1:0]                    Parity_Mode,
    input  logic                          Two_Stop,
    input  logic                          Read_Done,
    input  logic                          Clear_Ovf,
    output logic [DATA_BITS-1:0]          Data_Out,
    output logic [2:0]                    Rx_Error,
    output logic                          Data_Rdy,
    output logic                          FIFO_Empty,
    output logic                          FIFO_Full,
    output logic                          FIFO_Overflow,
    output logic                          RTS,
    output logic [$clog2(FIFO_DEPTH):0]   Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 3;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THR_C   = CW'(FULL_THRESH);
    localparam logic [CW-1:0] CONE    = CW'(1);
    localparam logic [AW-1:0] PONE    = AW'(1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] PARITY   = 3'd3;
    localparam logic [2:0] STOP     = 3'd4;
    localparam logic [2:0] BRK_WAIT = 3'd5;

    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [2:0]           state_q, state_d;
    logic [3:0]           tick_q, tick_d, bit_cnt_q, bit_cnt_d;
    logic [1:0]           vote_q, vote_d, pmode_q, pmode_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 zero_q, zero_d, two_stop_q, two_stop_d;
    logic                 wr_vld_q, wr_vld_d;
    logic [EW-1:0]        wr_dat_q, wr_dat_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d, rts_q, rts_d;
    logic [EW-1:0]        hold_q, hold_d;

    logic maj, mid, last, par_en, fe, zb, pop, wr_ok;
    logic [EW-1:0] head;

    always_comb begin
        rx_s1_d    = Rx;
        rx_s2_d    = rx_s1_q;
        state_d    = state_q;
        tick_d     = tick_q;
        bit_cnt_d  = bit_cnt_q;
        vote_d     = vote_q;
        pmode_d    = pmode_q;
        shift_d    = shift_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        two_stop_d = two_stop_q;
        wr_vld_d   = 1'b0;
        wr_dat_d   = wr_dat_q;
        maj    = ({1'b0, vote_q} + {2'b00, rx_s2_q}) >= 3'd2;
        mid    = Baud_Tick && (tick_q == 4'd9);
        last   = Baud_Tick && (tick_q == 4'd15);
        par_en = (pmode_q == 2'b01) || (pmode_q == 2'b10);
        fe     = ferr_q | ~maj;
        zb     = (bit_cnt_q == 4'd0) ? (zero_q & ~maj) : zero_q;

        // Ticks 7 and 8 accumulate votes; the tick-9 sample completes the majority in maj.
        if (Baud_Tick && state_q != IDLE && state_q != BRK_WAIT) begin
            tick_d = tick_q + 4'd1;
            if (tick_q == 4'd7 || tick_q == 4'd8) vote_d = vote_q + {1'b0, rx_s2_q};
            if (tick_q == 4'd9) vote_d = 2'd0;
        end

        case (state_q)
            IDLE: begin
                tick_d = 4'd0;
                vote_d = 2'd0;
                if (!rx_s2_q) begin
                    state_d    = START;
                    two_stop_d = Two_Stop;
                    pmode_d    = Parity_Mode;
                    bit_cnt_d  = 4'd0;
                    par_d      = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    zero_d     = 1'b1;
                end
            end
            START: begin
                if (mid && maj) state_d = IDLE;
                else if (last) state_d = DATA;
            end
            DATA: begin
                if (mid) begin
                    if (MSB_FIRST != 0) shift_d = {shift_q[DATA_BITS-2:0], maj};
                    else                shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    par_d = par_q ^ maj;
                    if (maj) zero_d = 1'b0;
                end
                if (last) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 4'd0;
                        state_d   = par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (mid) begin
                    perr_d = (par_q ^ maj) != pmode_q[1];
                    if (maj) zero_d = 1'b0;
                end
                if (last) state_d = STOP;
            end
            STOP: begin
                if (mid) begin
                    if (bit_cnt_q == 4'd0 && two_stop_q) begin
                        ferr_d = fe;
                        zero_d = zb;
                    end else begin
                        // A break reports only the break bit; parity/frame results are meaningless then.
                        wr_vld_d = 1'b1;
                        wr_dat_d = zb ? {3'b001, shift_q} : {fe, perr_q, 1'b0, shift_q};
                        state_d  = zb ? BRK_WAIT : IDLE;
                        tick_d   = 4'd0;
                    end
                end
                if (last) bit_cnt_d = bit_cnt_q + 4'd1;
            end
            BRK_WAIT: begin
                if (!rx_s2_q) tick_d = 4'd0;
                else if (Baud_Tick) begin
                    if (tick_q == 4'd15) state_d = IDLE;
                    else tick_d = tick_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;
        pop     = Read_Done && (count_q != '0);
        wr_ok   = wr_vld_q && ((count_q != DEPTH_C) || pop);
        if (wr_ok) begin
            mem_d[wptr_q] = wr_dat_q;
            wptr_d        = wptr_q + PONE;
        end
        if (pop) begin
            hold_d = mem_q[rptr_q];
            rptr_d = rptr_q + PONE;
        end
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + CONE;
            2'b01:   count_d = count_q - CONE;
            default: count_d = count_q;
        endcase
        if (Clear_Ovf) ovf_d = 1'b0;
        if (wr_vld_q && !wr_ok) ovf_d = 1'b1;
        rts_d = !(count_q >= THR_C);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            state_q    <= IDLE;
            tick_q     <= 4'd0;
            bit_cnt_q  <= 4'd0;
            vote_q     <= 2'd0;
            pmode_q    <= 2'd0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            two_stop_q <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_dat_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rts_q      <= 1'b1;
            hold_q     <= '0;
        end else begin
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            pmode_q    <= pmode_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            two_stop_q <= two_stop_d;
            wr_vld_q   <= wr_vld_d;
            wr_dat_q   <= wr_dat_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rts_q      <= rts_d;
            hold_q     <= hold_d;
        end
    end

    // Once drained, the last popped entry stays visible rather than a stale slot.
    assign head          = (count_q == '0) ? hold_q : mem_q[rptr_q];
    assign Data_Out      = head[DATA_BITS-1:0];
    assign Rx_Error      = head[EW-1:DATA_BITS];
    assign Data_Rdy      = (count_q != '0);
    assign FIFO_Empty    = (count_q == '0);
    assign FIFO_Full     = (count_q >= THR_C);
    assign FIFO_Overflow = ovf_q;
    assign RTS           = rts_q;
    assign Count         = count_q;
endmodule

// File: tb/tb_uart_rx_fifo_v2.sv
// Directed bench: MSB-first default instance plus an LSB-first instance on a shared clock/tick.
module tb_uart_rx_fifo_v2;
    logic       Clk = 1'b0, Rst = 1'b0, Baud_Tick = 1'b0;
    logic       rx_m = 1'b1, rx_l = 1'b1;
    logic [1:0] Parity_Mode = 2'b00;
    logic       Two_Stop = 1'b0, Read_Done = 1'b0, Clear_Ovf = 1'b0;
    logic [7:0] dout_m, dout_l;
    logic [2:0] err_m, err_l;
    logic       rdy_m, rdy_l, emp_m, emp_l, full_m, full_l, ovf_m, ovf_l, rts_m, rts_l;
    logic [3:0] cnt_m, cnt_l;
    int errors = 0;
    int checks = 0;

    uart_rx_fifo_v2 u_dut (
        .Clk(Clk), .Rst(Rst), .Baud_Tick(Baud_Tick), .Rx(rx_m), .Parity_Mode(Parity_Mode),
        .Two_Stop(Two_Stop), .Read_Done(Read_Done), .Clear_Ovf(Clear_Ovf), .Data_Out(dout_m),
        .Rx_Error(err_m), .Data_Rdy(rdy_m), .FIFO_Empty(emp_m), .FIFO_Full(full_m),
        .FIFO_Overflow(ovf_m), .RTS(rts_m), .Count(cnt_m));

    uart_rx_fifo_v2 #(.MSB_FIRST(0)) u_lsb (
        .Clk(Clk), .Rst(Rst), .Baud_Tick(Baud_Tick), .Rx(rx_l), .Parity_Mode(Parity_Mode),
        .Two_Stop(Two_Stop), .Read_Done(1'b0), .Clear_Ovf(1'b0), .Data_Out(dout_l),
        .Rx_Error(err_l), .Data_Rdy(rdy_l), .FIFO_Empty(emp_l), .FIFO_Full(full_l),
        .FIFO_Overflow(ovf_l), .RTS(rts_l), .Count(cnt_l));

    initial forever #5 Clk = ~Clk;

    // 16x tick every 4 Clk, so one bit time is 64 Clk.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge Clk);
            Baud_Tick = (c == 3);
            c = (c + 1) % 4;
        end
    end

    task automatic drive(input bit tgt, input logic v, input int n);
        if (tgt) rx_l = v; else rx_m = v;
        repeat (n) @(negedge Clk);
    endtask

    // A zero final stop bit is cut short so the line is idle again before a spurious start could be sampled.
    task automatic send_frame(input bit tgt, input logic [7:0] d, input bit lsb, input bit par_en,
                              input bit pbit, input bit s0, input bit s1, input bit two);
        drive(tgt, 1'b0, 64);
        for (int i = 0; i < 8; i++) drive(tgt, lsb ? d[i] : d[7-i], 64);
        if (par_en) drive(tgt, pbit, 64);
        if (two) begin
            drive(tgt, s0, 64);
            drive(tgt, s1, s1 ? 64 : 50);
        end else begin
            drive(tgt, s0, s0 ? 64 : 50);
        end
        drive(tgt, 1'b1, 128);
    endtask

    task automatic pop;
        @(negedge Clk) Read_Done = 1'b1;
        @(negedge Clk) Read_Done = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (cnt_m !== 4'd0 || emp_m !== 1'b1 || rdy_m !== 1'b0) begin errors++; $display("FAIL rst_cnt_flags cnt=%0d emp=%b rdy=%b want 0/1/0", cnt_m, emp_m, rdy_m); end
        checks++; if (full_m !== 1'b0 || ovf_m !== 1'b0 || rts_m !== 1'b1) begin errors++; $display("FAIL rst_full_ovf_rts got %b%b%b want 001", full_m, ovf_m, rts_m); end
        checks++; if (dout_m !== 8'h00 || err_m !== 3'b000) begin errors++; $display("FAIL rst_head got %h/%b want 00/000", dout_m, err_m); end
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_even_parity;
        Parity_Mode = 2'b01; Two_Stop = 1'b1;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (dout_m !== 8'hA5 || err_m !== 3'b000) begin errors++; $display("FAIL even_a5 got %h/%b want a5/000", dout_m, err_m); end
        checks++; if (cnt_m !== 4'd1 || rdy_m !== 1'b1) begin errors++; $display("FAIL even_cnt got %0d rdy=%b want 1/1", cnt_m, rdy_m); end
        pop();
        checks++; if (emp_m !== 1'b1 || cnt_m !== 4'd0) begin errors++; $display("FAIL even_pop emp=%b cnt=%0d want 1/0", emp_m, cnt_m); end
        checks++; if (dout_m !== 8'hA5) begin errors++; $display("FAIL hold_empty got %h want a5", dout_m); end
    endtask

    task automatic test_odd_parity;
        Parity_Mode = 2'b10; Two_Stop = 1'b0;
        send_frame(1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (dout_m !== 8'hAA || err_m !== 3'b010) begin errors++; $display("FAIL odd_perr got %h/%b want aa/010", dout_m, err_m); end
        pop();
    endtask

    task automatic test_frame_break;
        Parity_Mode = 2'b00; Two_Stop = 1'b1;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (dout_m !== 8'h3C || err_m !== 3'b100) begin errors++; $display("FAIL frame_err got %h/%b want 3c/100", dout_m, err_m); end
        pop();
        drive(1'b0, 1'b0, 13 * 64);
        checks++; if (cnt_m !== 4'd1 || dout_m !== 8'h00 || err_m !== 3'b001) begin errors++; $display("FAIL break got cnt=%0d %h/%b want 1 00/001", cnt_m, dout_m, err_m); end
        drive(1'b0, 1'b1, 32);
        drive(1'b0, 1'b0, 12 * 64);
        checks++; if (cnt_m !== 4'd1) begin errors++; $display("FAIL brk_wait_hold cnt=%0d want 1", cnt_m); end
        drive(1'b0, 1'b1, 128);
        Two_Stop = 1'b0;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cnt_m !== 4'd2) begin errors++; $display("FAIL after_brk_cnt got %0d want 2", cnt_m); end
        pop();
        checks++; if (dout_m !== 8'h5A || err_m !== 3'b000) begin errors++; $display("FAIL after_brk_word got %h/%b want 5a/000", dout_m, err_m); end
        pop();
    endtask

    task automatic test_full_rts;
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cnt_m !== 4'd4 || full_m !== 1'b0 || rts_m !== 1'b1) begin errors++; $display("FAIL below_thr cnt=%0d full=%b rts=%b want 4/0/1", cnt_m, full_m, rts_m); end
        send_frame(1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cnt_m !== 4'd5 || full_m !== 1'b1 || rts_m !== 1'b0) begin errors++; $display("FAIL at_thr cnt=%0d full=%b rts=%b want 5/1/0", cnt_m, full_m, rts_m); end
        pop();
        checks++; if (full_m !== 1'b0 || rts_m !== 1'b1 || dout_m !== 8'd1) begin errors++; $display("FAIL thr_release full=%b rts=%b dout=%h want 0/1/01", full_m, rts_m, dout_m); end
        repeat (4) pop();
        checks++; if (emp_m !== 1'b1) begin errors++; $display("FAIL drain emp=%b want 1", emp_m); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (ovf_m !== 1'b1 || cnt_m !== 4'd8) begin errors++; $display("FAIL ovf_set ovf=%b cnt=%0d want 1/8", ovf_m, cnt_m); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dout_m !== 8'(i)) begin errors++; $display("FAIL ovf_read%0d got %h want %h", i, dout_m, 8'(i)); end
            pop();
        end
        checks++; if (emp_m !== 1'b1 || ovf_m !== 1'b1) begin errors++; $display("FAIL ovf_lost emp=%b ovf=%b want 1/1", emp_m, ovf_m); end
        @(negedge Clk) Clear_Ovf = 1'b1;
        @(negedge Clk) Clear_Ovf = 1'b0;
        checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf_m); end
    endtask

    task automatic test_glitch;
        drive(1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, 128);
        checks++; if (cnt_m !== 4'd0) begin errors++; $display("FAIL glitch cnt=%0d want 0", cnt_m); end
    endtask

    task automatic test_lsb_first;
        send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (dout_l !== 8'h01 || err_l !== 3'b000 || cnt_l !== 4'd1) begin errors++; $display("FAIL lsb_first got %h/%b cnt=%0d want 01/000 1", dout_l, err_l, cnt_l); end
        checks++; if (cnt_m !== 4'd0) begin errors++; $display("FAIL lsb_isolation cnt=%0d want 0", cnt_m); end
    endtask

    task automatic test_reset_midframe;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cnt_m !== 4'd1) begin errors++; $display("FAIL pre_rst cnt=%0d want 1", cnt_m); end
        drive(1'b0, 1'b0, 64);
        drive(1'b0, 1'b1, 64);
        drive(1'b0, 1'b0, 64);
        Rst = 1'b0;
        #1;
        checks++; if (cnt_m !== 4'd0 || emp_m !== 1'b1) begin errors++; $display("FAIL mid_rst cnt=%0d emp=%b want 0/1", cnt_m, emp_m); end
        drive(1'b0, 1'b1, 8);
        Rst = 1'b1;
        drive(1'b0, 1'b1, 128);
        send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cnt_m !== 4'd1 || dout_m !== 8'h96 || err_m !== 3'b000) begin errors++; $display("FAIL post_rst got cnt=%0d %h/%b want 1 96/000", cnt_m, dout_m, err_m); end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_frame_break();
        test_full_rts();
        test_overflow();
        test_glitch();
        test_lsb_first();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
